// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the multiplexed 7-seg read-back path.
// Contents: active-low segment patterns {a,b,c,d,e,f,g}, segment bit indices, FSM encoding.
// Used by seg_pattern_decode and seg_scan_decoder (optional hex set: SEG_DEC_HEX_EN).
package seg_pkg;

    // Active-low patterns, bit 6 = segment a ... bit 0 = segment g.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b1100000;
    localparam logic [6:0] SEG_HEX_C = 7'b0110001;
    localparam logic [6:0] SEG_HEX_D = 7'b1000010;
    localparam logic [6:0] SEG_HEX_E = 7'b0110000;
    localparam logic [6:0] SEG_HEX_F = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Bit position of each segment inside the 7-bit bus.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Stability FSM: SETTLE while counting equal samples, HELD once the dwell was captured.
    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_HELD   = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: active-low 7-seg pattern -> {err, value[3:0]}, purely combinational.
// Ports: seg (pattern in), value (decoded nibble, 4'hF when illegal), err (illegal pattern).
// Macro SEG_DEC_HEX_EN: when defined, A/b/C/d/E/F glyphs decode to 4'hA..4'hF without error.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       err
);

    logic [6:0] pat;

    // Re-pack by named segment so the pattern constants stay in {a..g} order
    // regardless of how the bus is wired.
    assign pat = {seg[SEG_A], seg[SEG_B], seg[SEG_C], seg[SEG_D],
                  seg[SEG_E], seg[SEG_F], seg[SEG_G]};

    always_comb begin
        value = 4'hF;
        err   = 1'b0;
        case (pat)
            SEG_0:     value = 4'h0;
            SEG_1:     value = 4'h1;
            SEG_2:     value = 4'h2;
            SEG_3:     value = 4'h3;
            SEG_4:     value = 4'h4;
            SEG_5:     value = 4'h5;
            SEG_6:     value = 4'h6;
            SEG_7:     value = 4'h7;
            SEG_8:     value = 4'h8;
            SEG_9:     value = 4'h9;
`ifdef SEG_DEC_HEX_EN
            SEG_HEX_A: value = 4'hA;
            SEG_HEX_B: value = 4'hB;
            SEG_HEX_C: value = 4'hC;
            SEG_HEX_D: value = 4'hD;
            SEG_HEX_E: value = 4'hE;
            SEG_HEX_F: value = 4'hF;
`endif
            default: begin
                value = 4'hF;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed active-low 7-seg bus and rebuilds the shown digits.
// Ports: clk, rst_n (async low), an/seg (display bus), clear (drop partial frame),
//        digits/digit_err (last complete frame), frame_valid (1-cycle publish pulse).
// Capture on edge STABLE_CYCLES+3 after a stable input change; macro SEG_DEC_HEX_EN adds hex.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid
);

    // Synchroniser and previous-sample registers; reset to "blank, nothing selected".
    logic [NUM_DIGITS-1:0] an_s1, an_s2, an_prev;
    logic [6:0]            seg_s1, seg_s2, seg_prev;

    scan_state_t           state, state_nxt;
    logic [CNT_W-1:0]      cnt;

    logic [4*NUM_DIGITS-1:0] shadow, shadow_m;
    logic [NUM_DIGITS-1:0]   shadow_err, shadow_err_m;
    logic [NUM_DIGITS-1:0]   seen;

    logic                  changed;
    logic                  cnt_done;
    logic                  capture_evt;
    logic [NUM_DIGITS-1:0] sel;
    logic                  sel_onehot;
    logic                  capture;
    logic                  frame_done;
    logic [3:0]            dec_value;
    logic                  dec_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1    <= '1;
            an_s2    <= '1;
            an_prev  <= '1;
            seg_s1   <= SEG_BLANK;
            seg_s2   <= SEG_BLANK;
            seg_prev <= SEG_BLANK;
        end else begin
            an_s1    <= an;
            an_s2    <= an_s1;
            an_prev  <= an_s2;
            seg_s1   <= seg;
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
        end
    end

    assign changed  = (an_s2 != an_prev) || (seg_s2 != seg_prev);
    assign cnt_done = (cnt == CNT_W'(STABLE_CYCLES - 1));

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_SETTLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (changed) begin
            state_nxt = ST_SETTLE;
        end else if (state == ST_SETTLE && cnt_done) begin
            state_nxt = ST_HELD;
        end
    end

    // FSM: outputs. HELD suppresses further captures until the bus changes again.
    always_comb begin
        capture_evt = 1'b0;
        if (!changed && state == ST_SETTLE && cnt_done) begin
            capture_evt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (changed) begin
            cnt <= '0;
        end else if (state == ST_SETTLE && !cnt_done) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Selected digit as an active-high mask; only a single selected anode is capturable.
    assign sel        = ~an_s2;
    assign sel_onehot = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    assign capture    = capture_evt && sel_onehot;

    seg_pattern_decode u_decode (
        .seg   (seg_s2),
        .value (dec_value),
        .err   (dec_err)
    );

    // Shadow with the digit being captured merged in, used for both update and publish.
    always_comb begin
        shadow_m     = shadow;
        shadow_err_m = shadow_err;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
                shadow_m[4*i +: 4] = dec_value;
                shadow_err_m[i]    = dec_err;
            end
        end
    end

    assign frame_done = capture && ((seen | sel) == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            shadow_err <= '0;
            seen       <= '0;
        end else if (clear) begin
            shadow     <= '0;
            shadow_err <= '0;
            seen       <= '0;
        end else if (capture) begin
            shadow     <= shadow_m;
            shadow_err <= shadow_err_m;
            seen       <= frame_done ? '0 : (seen | sel);
        end
    end

    // clear wins over a completing capture: the previous frame stays published.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done && !clear;
            if (frame_done && !clear) begin
                digits    <= shadow_m;
                digit_err <= shadow_err_m;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scan sequences with a frame scoreboard.
// Stimulus pushes the expected {digits, digit_err} before the completing dwell;
// a monitor pops on every frame_valid pulse and compares.
module tb_seg_scan_decoder;
    import seg_pkg::*;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          clear;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_err;
    logic          frame_valid;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [4*ND-1:0] dig;
        logic [ND-1:0]   err;
    } frame_t;

    frame_t exp_q[$];

    always #5 clk = ~clk;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(8), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .clear       (clear),
        .digits      (digits),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every published frame must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_frame: got digits=%h err=%b, expected no frame",
                         digits, digit_err);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                check("frame_digits", 32'(digits), 32'(e.dig));
                check("frame_err", 32'(digit_err), 32'(e.err));
            end
        end
    end

    task automatic dwell(input logic [ND-1:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [4*ND-1:0] d, input logic [ND-1:0] e);
        frame_t f;
        f.dig = d;
        f.err = e;
        exp_q.push_back(f);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 40;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        an    = 4'b1111;
        seg   = SEG_BLANK;
        clear = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_err", 32'(digit_err), 32'h0);
        check("reset_fv", 32'(frame_valid), 32'h0);
        rst_n = 1'b1;
        dwell(4'b1111, SEG_BLANK, 5);

        // 1: plain scan 3,4,5,8
        dwell(4'b1110, SEG_3, 20);
        dwell(4'b1101, SEG_4, 20);
        dwell(4'b1011, SEG_5, 20);
        expect_frame(16'h8543, 4'b0000);
        dwell(4'b0111, SEG_8, 20);
        drain("t1_drain");

        // 2: 3-cycle glitch inside digit 0 dwell is filtered; 9 is re-captured
        dwell(4'b1110, SEG_9, 14);
        dwell(4'b1110, SEG_1, 3);
        dwell(4'b1110, SEG_9, 14);
        dwell(4'b1101, SEG_1, 20);
        dwell(4'b1011, SEG_2, 20);
        expect_frame(16'h7219, 4'b0000);
        dwell(4'b0111, SEG_7, 20);
        drain("t2_drain");

        // 3: a 5-cycle dwell of 6 on digit 1 is never captured
        dwell(4'b1110, SEG_0, 20);
        dwell(4'b1101, SEG_6, 5);
        dwell(4'b1101, SEG_5, 20);
        dwell(4'b1011, SEG_6, 20);
        expect_frame(16'h4650, 4'b0000);
        dwell(4'b0111, SEG_4, 20);
        drain("t3_drain");

        // 4: hex 'A' glyph on digit 2
        dwell(4'b1110, SEG_1, 20);
        dwell(4'b1101, SEG_2, 20);
        dwell(4'b1011, SEG_HEX_A, 20);
`ifdef SEG_DEC_HEX_EN
        expect_frame(16'h3A21, 4'b0000);
`else
        expect_frame(16'h3F21, 4'b0100);
`endif
        dwell(4'b0111, SEG_3, 20);
        drain("t4_drain");

        // 5: multiple / no anodes selected are ignored
        dwell(4'b1100, SEG_8, 20);
        dwell(4'b1111, SEG_8, 20);
        dwell(4'b1110, SEG_9, 20);
        dwell(4'b1101, SEG_8, 20);
        dwell(4'b1011, SEG_7, 20);
        dwell(4'b1111, SEG_BLANK, 20);
        expect_frame(16'h6789, 4'b0000);
        dwell(4'b0111, SEG_6, 20);
        drain("t5_drain");

        // 6: clear after 3 digits, then reset mid-dwell
        dwell(4'b1110, SEG_1, 20);
        dwell(4'b1101, SEG_1, 20);
        dwell(4'b1011, SEG_1, 20);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        dwell(4'b0111, SEG_1, 20);
        dwell(4'b1110, SEG_2, 10);
        rst_n = 1'b0;
        #1;
        check("rst_mid_digits", 32'(digits), 32'h0);
        check("rst_mid_err", 32'(digit_err), 32'h0);
        check("rst_mid_fv", 32'(frame_valid), 32'h0);
        dwell(4'b1111, SEG_BLANK, 4);
        rst_n = 1'b1;
        dwell(4'b1111, SEG_BLANK, 5);
        dwell(4'b1110, SEG_2, 20);
        dwell(4'b1101, SEG_0, 20);
        dwell(4'b1011, SEG_4, 20);
        expect_frame(16'h8402, 4'b0000);
        dwell(4'b0111, SEG_8, 20);
        drain("t6_drain");
        check("final_digits", 32'(digits), 32'h8402);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
